// File: rtl/count_result_fifo.sv
// count_result_fifo
//   Watches the one-hot T0/T1/T2 start/count controller and its counter Q.
//   Each completed run (busy = T1|T2 falling back to T0) captures the final Q
//   and the run length into a small FIFO, which a valid/ready reader drains.
//   Sticky flags report dropped completions, multi-hot controller states and
//   runs that ended in the all-zero (controller reset) state.
//   Optional feature macro: CYCLE_COUNT_EN. When it is defined, the run-length
//   counter and the cycles field are built. When it is undefined, rd_cycles
//   reads as zero.
module count_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CYC_W  = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     T0,
    input  logic                     T1,
    input  logic                     T2,
    input  logic [DATA_W-1:0]        Q,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_q,
    output logic [CYC_W-1:0]         rd_cycles,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     state_err,
    output logic                     aborted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // True when more than one controller state bit is high.
    function automatic logic multi_hot(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic              busy_s;
    logic              busy_q;
    logic              complete_s;
    logic              abort_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              state_err_q, state_err_d;
    logic              aborted_q, aborted_d;
    logic [DATA_W-1:0] q_mem_q [DEPTH];

    // A multi-hot cycle still counts as busy whenever T1 or T2 is high.
    assign busy_s     = T1 | T2;
    assign complete_s = ~busy_s & busy_q & T0;
    assign abort_s    = ~busy_s & busy_q & ~T0;
    assign pop_s      = rd_valid_q & rd_ready;
    assign full_s     = (level_q == FULL_LVL);
    // When full, a completion is stored only if the head leaves in the same cycle.
    assign wr_en_s    = complete_s & (~full_s | pop_s);
    assign drop_s     = complete_s & full_s & ~pop_s;

    // Next-state for pointers, occupancy, valid and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        state_err_d = state_err_q;
        aborted_d   = aborted_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        if (multi_hot(T0, T1, T2)) begin
            state_err_d = 1'b1;
        end else begin
            state_err_d = state_err_q;
        end

        if (abort_s) begin
            aborted_d = 1'b1;
        end else begin
            aborted_d = aborted_q;
        end

        rd_valid_d = (level_d != {LVL_W{1'b0}});
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            busy_q      <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            state_err_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            busy_q      <= busy_s;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            state_err_q <= state_err_d;
            aborted_q   <= aborted_d;
        end
    end

    // Captured Q storage, cleared so the head reads zero out of reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            q_mem_q[wr_ptr_q] <= Q;
        end else begin
            q_mem_q[wr_ptr_q] <= q_mem_q[wr_ptr_q];
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [CYC_W-1:0] run_cnt_q, run_cnt_d;
    logic [CYC_W-1:0] cyc_mem_q [DEPTH];

    // Run length: loads 1 on the first busy cycle, then counts up and saturates.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (busy_s && !busy_q) begin
            run_cnt_d = CYC_W'(1);
        end else if (busy_s && (run_cnt_q != {CYC_W{1'b1}})) begin
            run_cnt_d = run_cnt_q + CYC_W'(1);
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Run-length counter register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            run_cnt_q <= {CYC_W{1'b0}};
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    // Run-length storage, written alongside the captured Q.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cyc_mem_q[i] <= {CYC_W{1'b0}};
            end
        end else if (wr_en_s) begin
            cyc_mem_q[wr_ptr_q] <= run_cnt_q;
        end else begin
            cyc_mem_q[wr_ptr_q] <= cyc_mem_q[wr_ptr_q];
        end
    end

    assign rd_cycles = cyc_mem_q[rd_ptr_q];
`else
    assign rd_cycles = {CYC_W{1'b0}};
`endif

    assign rd_valid  = rd_valid_q;
    assign rd_q      = q_mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign state_err = state_err_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_count_result_fifo.sv
// Directed bench for count_result_fifo (DATA_W=4, DEPTH=4, CYC_W=8).
// The expected cycles field depends on whether CYCLE_COUNT_EN is defined.
module tb_count_result_fifo;

    logic       CLK = 1'b0;
    logic       reset;
    logic       T0, T1, T2;
    logic [3:0] Q;
    logic       rd_ready;
    logic       rd_valid;
    logic [3:0] rd_q;
    logic [7:0] rd_cycles;
    logic [2:0] level;
    logic       overflow, state_err, aborted;

    int n_vec = 0;
    int n_err = 0;

    count_result_fifo #(.DATA_W(4), .DEPTH(4), .CYC_W(8)) dut (
        .CLK(CLK), .reset(reset), .T0(T0), .T1(T1), .T2(T2), .Q(Q),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_q(rd_q),
        .rd_cycles(rd_cycles), .level(level), .overflow(overflow),
        .state_err(state_err), .aborted(aborted)
    );

    always #5 CLK = ~CLK;

    // Expected cycles field for a run of n busy cycles.
    function automatic int exp_cyc(input int n);
`ifdef CYCLE_COUNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then step to just after the rising edge.
    task automatic cyc(input logic t0, input logic t1, input logic t2,
                       input logic [3:0] q, input logic rdy);
        T0 = t0; T1 = t1; T2 = t2; Q = q; rd_ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    // n busy cycles in T1 followed by a T0 completion cycle carrying q.
    task automatic run(input int n, input logic [3:0] q, input logic rdy_end);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, q, rdy_end);
    endtask

    task automatic do_reset();
        T0 = 1'b0; T1 = 1'b0; T2 = 1'b0; Q = 4'h0; rd_ready = 1'b0;
        reset = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        reset = 1'b1;
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_valid"}, 32'(rd_valid), 0);
        check_val({tag, "_level"}, 32'(level), 0);
    endtask

    initial begin
        // 1: reset and idle all-zero
        do_reset();
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check_empty("rst");
        check_val("rst_rdq", 32'(rd_q), 0);
        check_val("rst_cyc", 32'(rd_cycles), 0);
        check_val("rst_ovf", 32'(overflow), 0);
        check_val("rst_serr", 32'(state_err), 0);
        check_val("rst_abort", 32'(aborted), 0);

        // 2: T0 -> T1 x3 -> T2 x2 -> T0 with Q=B
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'hB, 1'b0);
        check_val("r1_valid", 32'(rd_valid), 1);
        check_val("r1_rdq", 32'(rd_q), 32'hB);
        check_val("r1_cyc", 32'(rd_cycles), exp_cyc(5));
        check_val("r1_level", 32'(level), 1);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        check_empty("r1_pop");
        // pop when empty has no effect
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        check_empty("pop_empty");

        // 3: five completions into a 4-deep FIFO, then drain
        for (int i = 1; i <= 5; i++) run(i, 4'(i), 1'b0);
        check_val("ovf_level", 32'(level), 4);
        check_val("ovf_flag", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            check_val("drain_valid", 32'(rd_valid), 1);
            check_val("drain_rdq", 32'(rd_q), i);
            check_val("drain_cyc", 32'(rd_cycles), exp_cyc(i));
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        end
        check_empty("drained");

        // 4: full FIFO, completion coincident with a pop
        do_reset();
        for (int i = 1; i <= 4; i++) run(i, 4'(i), 1'b0);
        check_val("full_level", 32'(level), 4);
        check_val("full_head", 32'(rd_q), 1);
        run(2, 4'h6, 1'b1);
        check_val("pp_level", 32'(level), 4);
        check_val("pp_ovf", 32'(overflow), 0);
        check_val("pp_head", 32'(rd_q), 2);
        for (int i = 0; i < 4; i++) begin
            check_val("pp_rdq", 32'(rd_q), (i == 3) ? 6 : i + 2);
            check_val("pp_cyc", 32'(rd_cycles), exp_cyc((i == 3) ? 2 : i + 2));
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        end
        check_empty("pp_drained");

        // 5: abort to all-zero, then multi-hot state
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'h3, 1'b0);
        check_val("abort_flag", 32'(aborted), 1);
        check_empty("abort");
        check_val("abort_serr", 32'(state_err), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'h5, 1'b0);
        check_empty("idle_zero");
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        check_val("serr_flag", 32'(state_err), 1);
        cyc(1'b1, 1'b0, 1'b0, 4'h9, 1'b0);
        check_val("serr_push_rdq", 32'(rd_q), 9);
        check_val("serr_push_cyc", 32'(rd_cycles), exp_cyc(1));
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check_val("serr_sticky", 32'(state_err), 1);
        check_val("abort_sticky", 32'(aborted), 1);

        // Reset mid-run: partial run discarded, not counted as aborted
        do_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 4'h4, 1'b0);
        check_empty("midrst");
        check_val("midrst_abort", 32'(aborted), 0);

        // 6: 300-cycle run saturates the cycles field
        run(300, 4'h7, 1'b0);
        check_val("sat_valid", 32'(rd_valid), 1);
        check_val("sat_rdq", 32'(rd_q), 7);
        check_val("sat_cyc", 32'(rd_cycles), exp_cyc(300));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
